// File: rtl/regfile_arbiter.sv
// Two-port arbiter in front of a single-port register file: round-robin between core (port 0)
// and host (port 1), with a bounded burst lock for the host and a fixed one-cycle response path.
module regfile_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic        [ADDR_W-1:0] addr0_a,
    input  logic        [ADDR_W-1:0] addr0_b,
    input  logic        [ADDR_W-1:0] addr1_a,
    input  logic        [ADDR_W-1:0] addr1_b,
    input  logic signed [DATA_W-1:0] wdata0,
    input  logic signed [DATA_W-1:0] wdata1,
    input  logic                     lock1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic signed [DATA_W-1:0] rdata0_a,
    output logic signed [DATA_W-1:0] rdata0_b,
    output logic signed [DATA_W-1:0] rdata1_a,
    output logic signed [DATA_W-1:0] rdata1_b,
    output logic        [ADDR_W-1:0] rf_addr_a,
    output logic        [ADDR_W-1:0] rf_addr_b,
    output logic                     rf_we,
    output logic signed [DATA_W-1:0] rf_wdata,
    input  logic signed [DATA_W-1:0] rf_data_a,
    input  logic signed [DATA_W-1:0] rf_data_b
);

    localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

    // r_lastGnt holds the index of the most recently granted port
    logic       r_lastGnt;
    logic [3:0] r_lockCnt;
    logic       r_rvalid0;
    logic       r_rvalid1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_lockSat;

    assign w_lockSat = (r_lockCnt >= LOCK_LIMIT);

    // Once the host burst hits its limit, a waiting core request gets exactly one slot
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (req1 && lock1) begin
                if (w_lockSat && req0) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (req0 && req1) begin
                if (r_lastGnt) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastGnt <= 1'b1;
            r_lockCnt <= 4'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            if (w_gnt0) begin
                r_lastGnt <= 1'b0;
                r_lockCnt <= 4'd0;
            end else if (w_gnt1) begin
                r_lastGnt <= 1'b1;
                if (!lock1) begin
                    r_lockCnt <= 4'd0;
                end else if (!w_lockSat) begin
                    r_lockCnt <= r_lockCnt + 4'd1;
                end
            end
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    assign rf_addr_a = w_gnt1 ? addr1_a : addr0_a;
    assign rf_addr_b = w_gnt1 ? addr1_b : addr0_b;
    assign rf_wdata  = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
    assign rf_we     = (w_gnt0 && we0) || (w_gnt1 && we1);

    // Gating with rst_n hides a response left over from a grant issued just before reset
    assign rvalid0  = r_rvalid0 && rst_n;
    assign rvalid1  = r_rvalid1 && rst_n;
    assign rdata0_a = rvalid0 ? rf_data_a : '0;
    assign rdata0_b = rvalid0 ? rf_data_b : '0;
    assign rdata1_a = rvalid1 ? rf_data_a : '0;
    assign rdata1_b = rvalid1 ? rf_data_b : '0;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, register data width; SHALL match the regfile data width.
REQ-002 Parameter ADDR_W, default 3, register address width.
REQ-003 Parameter MAX_LOCK, default 4, max consecutive locked grants to port 1 (range 1..15).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk is the single clock (all state on rising edge) and rst_n is the synchronous active-low reset.
REQ-005 Ports SHALL be:
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 req0 / req1  in  1  port 0 (core) / port 1 (host) access request
 we0 / we1  in  1  request is a write (write goes to addr_a)
 addr0_a, addr0_b / addr1_a, addr1_b  in  ADDR_W  read/write addresses
 wdata0 / wdata1  in  DATA_W signed  write data
 lock1  in  1  port 1 burst lock
 gnt0 / gnt1  out  1  request accepted this cycle
 rvalid0 / rvalid1  out  1  response valid
 rdata0_a, rdata0_b / rdata1_a, rdata1_b  out  DATA_W signed  response data
 rf_addr_a, rf_addr_b  out  ADDR_W  regfile addresses
 rf_we  out  1  regfile write enable
 rf_wdata  out  DATA_W signed  regfile write data
 rf_data_a, rf_data_b  in  DATA_W signed  regfile registered read data

Function
REQ-006 At most one grant per cycle; gnt0 and gnt1 SHALL never be high together.
REQ-007 gnt SHALL be combinational from req*, lock1, and registered state; zero-bubble (grant possible every cycle).
REQ-008 Requester SHALL hold req and payload stable until its gnt is high; gnt high for exactly the cycle the request is accepted.
REQ-009 Only one req high: that port is granted, unless REQ-012 applies.
REQ-010 Both req high, no lock: round-robin; the port not granted most recently wins; last_gnt register updates on every grant.
REQ-011 Lock: while req1 and lock1 are high and lock_cnt < MAX_LOCK, port 1 wins regardless of req0; lock_cnt increments on each such grant.
REQ-012 When lock_cnt == MAX_LOCK and req0 is high, port 0 SHALL be granted for one cycle and lock_cnt SHALL clear; with req0 low, port 1 continues to be granted and lock_cnt saturates at MAX_LOCK.
REQ-013 lock_cnt SHALL clear whenever a grant goes to port 0, or lock1 is low in a cycle with gnt1.
REQ-014 rf_addr_a/rf_addr_b/rf_wdata SHALL mux the granted port's payload; with no grant, rf_addr_* hold port 0's addresses and rf_wdata = 0.
REQ-015 rf_we = granted port's we AND grant; rf_we = 0 with no grant.
REQ-016 Response latency is exactly 1 cycle: gnt_k in cycle N -> rvalid_k in cycle N+1 for one cycle, with rdata_k_a = rf_data_a and rdata_k_b = rf_data_b.
REQ-017 Write requests SHALL also produce rvalid; rdata_k_a then equals the written data (regfile read-after-write in the same edge).
REQ-018 Non-responding port's rdata SHALL be 0; rvalid0 and rvalid1 are never high together.
REQ-019 Back-to-back grants SHALL produce back-to-back rvalids, order preserved.

Reset
REQ-020 While rst_n is low at a clock edge: last_gnt <- 1 (port 0 wins the first tie), lock_cnt <- 0, response pipeline cleared.
REQ-021 During any cycle with rst_n low: gnt0 = gnt1 = 0, rf_we = 0, rvalid0 = rvalid1 = 0.
REQ-022 A grant in the cycle before reset assertion SHALL NOT produce rvalid after reset; the first post-reset rvalid follows a post-reset grant.

Verification
REQ-023 After reset, write via port 0: addr0_a = 3, wdata0 = -5 -> gnt0 the same cycle; rvalid0 the next cycle with rdata0_a = -5.
REQ-024 Both ports request continuously, no lock -> grants alternate 0,1,0,1; rvalids alternate one cycle later; never both high.
REQ-025 req0 and req1 high with lock1 = 1, MAX_LOCK = 4 -> gnt1 x4, gnt0 x1, gnt1 x4 ...; with req0 low, gnt1 is continuous.
REQ-026 Port 1 writes reg 5 = 0x7FFF; then port 0 reads addr0_a = 5 -> rvalid0 with rdata0_a = 0x7FFF.
REQ-027 Assert rst_n low in the cycle after gnt1 -> no rvalid1 during or after reset; the first tie after reset grants port 0.
